uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for the PDP-8 console (KL8-style keyboard side). Samples the `RxD` pin at 16x the baud rate, assembles 8N1 characters and presents them to the CPU's keyboard IOT logic through a sticky ready flag that the CPU clears. It is the receive-side counterpart of the console transmitter and sits inside `PDP8` on the 25 MHz system clock.

## Interface
- `TICK_DIV`, 163, system clocks per oversample tick; 25 MHz / (9600 × 16) ≈ 163. Legal range is 2–4095.
- `clk` input 1: system clock, 25 MHz.
- `reset` input 1: synchronous, active-high.
- `rx` input 1: raw serial line, asynchronous, idle high.
- `clear` input 1: single-cycle pulse from KCC/KRB; clears `ready`, `overrun` and `frame_err`.
- `data` output 8: last received character; LSB was received first.
- `ready` output 1: a character is available (keyboard flag).
- `overrun` output 1: a character completed while `ready` was already 1.
- `frame_err` output 1: the stop bit of the latest character was sampled low.
- `busy` output 1: the FSM is not in IDLE; used for panel LED.

## Operation
- `rx` passes through a 2-flop synchronizer, then a third register used for falling-edge detection. Synchronizer flops reset to 1.
- Tick generator: 12-bit counter counts 0..TICK_DIV-1, wraps, and emits a 1-cycle `tick` at wrap. It is free-running and is not restarted on a start edge, so worst-case phase error is 1 tick (1/16 bit).
- FSM states are IDLE, START, DATA, STOP and WAITIDLE.
  - IDLE: on a synchronized falling edge, clear the tick-phase counter `ph` (4 bits) and go to START.
  - START: count ticks. At `ph`=8, evaluate the majority of the samples taken at ticks 7, 8 and 9 (`ph`=9 closes the vote). If the majority is 1, it is a false start: go to IDLE with nothing reported. If it is 0, set `ph` to 9 and the bit counter to 0, then go to DATA.
  - DATA: each bit is the majority vote of samples at `ph` 7, 8 and 9 of that bit period (16 ticks per bit). Bits shift into a shift register from the MSB side. After bit 7's vote, go to STOP.
  - STOP: take the majority vote at mid-bit.
    - If the vote is 1: load the character (see below) and go to IDLE.
    - If the vote is 0: load the character with `frame_err`=1 and go to WAITIDLE.
  - WAITIDLE: stay until the synchronized `rx` is 1, then go to IDLE. This covers a break or stuck-low line, and prevents repeated garbage characters.
- Loading a character: `data` takes the shift register value and `ready` is set to 1.
  - If `ready` was 1 and there is no `clear` in the same cycle, `overrun` is set to 1. `data` is overwritten, so the newest character wins.
  - `frame_err` is written with the new stop-bit result. It is not sticky across characters, but it is cleared by `clear`.
- `clear` in the same cycle as a load: the load wins. `ready` stays 1, `data` takes the new value, and `overrun` is not set. `frame_err` reflects the new character.
- `clear` at any other time: the next cycle has `ready`, `overrun` and `frame_err` at 0. `data` is unchanged.
- `busy` is 1 in every state except IDLE.

## Timing
- All outputs are registered.
- Reset values: `data`=0, `ready`=0, `overrun`=0, `frame_err`=0, `busy`=0, FSM in IDLE, tick counter 0.
- `reset` asserted mid-character aborts the reception. Nothing is loaded, and reception restarts only on a fresh falling edge after reset deasserts. A line that is low at reset release is not a start until it goes high and then falls.
- Edge to START: 3 clocks of synchronizer and edge-detect latency.
- `ready` rises 1 clock after the STOP-bit vote tick. That is about 9.5 bit times plus 3 clocks after the start edge, i.e. (9 × 16 + 9) ticks.
- `clear` takes effect on the next clock edge. There is no back-pressure and no stall on the serial side.

## Test plan
Use TICK_DIV=4 in simulation (64 clocks per bit) for all scenarios below.
- Send 0x55 8N1 at exactly 64 clk/bit → `data`=0x55, `ready`=1, `overrun`=0, `frame_err`=0. `busy` falls within 1 tick after the stop mid-bit.
- Apply a 20-clock low glitch on an idle line → FSM returns to IDLE, `ready` stays 0, `data` unchanged.
- Send 0xA3 then 0x3C with no `clear` in between → `data`=0x3C, `ready`=1, `overrun`=1. A subsequent `clear` makes all three flags 0.
- Send 0x81 with a low stop bit and hold the line low for 5 bit times → `data`=0x81, `frame_err`=1. No second character appears. Next, send 0x7E after the line returns high → `data`=0x7E, `frame_err`=0.
- Pulse `clear` in the same cycle as the load of 0x42, with `ready` already 1 → `ready`=1, `data`=0x42, `overrun`=0.
- Assert `reset` in the middle of bit 4 of 0xFF, release it, then send 0x12 at 62 and at 66 clk/bit (±3%) → both received as 0x12 with no errors. The aborted 0xFF is never reported.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver for the console keyboard: 16x oversampling, 3-sample majority vote
// per bit, sticky ready flag with overrun and framing-error reporting.
`timescale 1ns/1ps

module uart_rx #(
    parameter int unsigned TICK_DIV = 163
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       clear,
    output logic [7:0] data,
    output logic       ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAITIDLE
    } state_t;

    localparam logic [11:0] TICK_LAST = 12'(TICK_DIV - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t      r_state;
    state_t      w_state_next;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic [1:0]  r_flush;
    logic        r_armed;
    logic        w_fall;

    logic [11:0] r_tick_cnt;
    logic        w_tick;

    logic [3:0]  r_ph;
    logic [3:0]  w_ph_inc;
    logic [1:0]  r_samp;
    logic        w_vote;
    logic        w_vote_tick;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitcnt;

    logic        w_ph_clr;
    logic        w_bit_clr;
    logic        w_shift_en;
    logic        w_load;

    logic [7:0]  r_data;
    logic        r_ready;
    logic        r_overrun;
    logic        r_frame_err;
    logic        r_busy;

    // Input synchronizer and falling-edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // The chain holds its reset value for two clocks after release; a start edge is only
    // accepted once the real line has been seen high, so a line stuck low at release is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush <= 2'd0;
            r_armed <= 1'b0;
        end else begin
            if (r_flush != 2'd2) begin
                r_flush <= r_flush + 2'd1;
            end
            if (r_flush == 2'd2 && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_fall = r_armed & r_sync3 & ~r_sync2;

    // Free-running oversample tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= 12'd0;
        end else if (w_tick) begin
            r_tick_cnt <= 12'd0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 12'd1;
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Votes land on the tick that advances the phase to 9; samples 7 and 8 are held in r_samp
    assign w_ph_inc    = r_ph + 4'd1;
    assign w_vote_tick = w_tick && (w_ph_inc == 4'd9);
    assign w_vote      = maj3(r_samp[1], r_samp[0], r_sync2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ph_clr     = 1'b0;
        w_bit_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_ph_clr     = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_vote_tick) begin
                    if (w_vote) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_bit_clr    = 1'b1;
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_vote_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_vote_tick) begin
                    w_load       = 1'b1;
                    w_state_next = w_vote ? S_IDLE : S_WAITIDLE;
                end
            end
            S_WAITIDLE: begin
                if (r_sync2) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Bit timing and assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ph <= 4'd0;
        end else if (w_ph_clr) begin
            r_ph <= 4'd0;
        end else if (w_tick && r_state != S_IDLE) begin
            r_ph <= w_ph_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tick && (w_ph_inc == 4'd7 || w_ph_inc == 4'd8)) begin
            r_samp <= {r_samp[0], r_sync2};
        end
        if (w_shift_en) begin
            r_shift <= {w_vote, r_shift[7:1]};
        end
        if (w_bit_clr) begin
            r_bitcnt <= 3'd0;
        end else if (w_shift_en) begin
            r_bitcnt <= r_bitcnt + 3'd1;
        end
    end

    // Character hand-off; a load in the same cycle as clear takes priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= 8'd0;
            r_ready     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_state_next != S_IDLE);
            if (w_load) begin
                r_data      <= r_shift;
                r_ready     <= 1'b1;
                r_overrun   <= clear ? 1'b0 : (r_overrun | r_ready);
                r_frame_err <= ~w_vote;
            end else if (clear) begin
                r_ready     <= 1'b0;
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign ready     = r_ready;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives 8N1 frames, keeps a character-level model of the
// keyboard flags and compares it against the outputs on every idle cycle.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int TD  = 4;
    localparam int CPB = 16 * TD;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    uart_rx #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .clear    (clear),
        .data     (data),
        .ready    (ready),
        .overrun  (overrun),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t_start  = 0;
    int t_fall   = -100000;
    int n_lat    = 0;
    logic busy_prev = 1'b0;
    bit   chk_en    = 1'b0;

    logic [7:0] m_data  = 8'd0;
    logic       m_ready = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_ferr  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy_prev && !busy) t_fall <= cyc;
        busy_prev <= busy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Every idle cycle: {data, ready, overrun, frame_err, busy} must equal the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs", {data, ready, overrun, frame_err, busy},
                  {m_data, m_ready, m_ovr, m_ferr, 1'b0});
        end
    end

    task automatic model_char(input logic [7:0] b, input logic stop_ok, input logic clr_same);
        m_ovr   = clr_same ? 1'b0 : (m_ovr | m_ready);
        m_ready = 1'b1;
        m_data  = b;
        m_ferr  = ~stop_ok;
    endtask

    task automatic model_clear();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_reset();
        model_clear();
        m_data = 8'd0;
    endtask

    // Called on a negedge; start bit begins immediately, LSB first
    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_lvl,
                              input int stop_len);
        logic [8:0] bits;
        bits    = {b, 1'b0};
        t_start = cyc;
        for (int i = 0; i < 9; i++) begin
            rx = bits[i];
            repeat (cpb) @(negedge clk);
        end
        rx = stop_lvl;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input int cpb);
        chk_en = 1'b0;
        send_frame(b, cpb, 1'b1, cpb);
        repeat (8) @(negedge clk);
        model_char(b, 1'b1, 1'b0);
        chk_en = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clear();
        chk_en = 1'b0;
        clear  = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic align_phase();
        while (cyc % TD != 0) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_ready", ready, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        chk_en = 1'b1;
        repeat (20) @(negedge clk);

        // 0x55 at the nominal rate; busy must drop shortly after the stop mid-bit
        chk_en = 1'b0;
        t_fall = -100000;
        send_frame(8'h55, CPB, 1'b1, CPB);
        repeat (8) @(negedge clk);
        model_char(8'h55, 1'b1, 1'b0);
        chk_en = 1'b1;
        check("x55_data", data, 8'h55);
        check("x55_ready", ready, 1'b1);
        check("x55_overrun", overrun, 1'b0);
        check("x55_frame_err", frame_err, 1'b0);
        check_range("x55_busy_fall", t_fall - t_start, CPB * 19 / 2, CPB * 19 / 2 + TD + 5);
        pulse_clear();
        check("clr_ready", ready, 1'b0);

        // Short low glitch is a false start
        chk_en = 1'b0;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch_ready", ready, 1'b0);
        check("glitch_data", data, 8'h55);

        // Two characters without clear
        frame(8'hA3, CPB);
        frame(8'h3C, CPB);
        check("ovr_data", data, 8'h3C);
        check("ovr_ready", ready, 1'b1);
        check("ovr_overrun", overrun, 1'b1);
        pulse_clear();
        check("ovr_clr_flags", {ready, overrun, frame_err}, 3'b000);
        check("ovr_clr_data", data, 8'h3C);

        // Low stop bit then line held low: one framed character only
        chk_en = 1'b0;
        send_frame(8'h81, CPB, 1'b0, 5 * CPB);
        repeat (10) @(negedge clk);
        model_char(8'h81, 1'b0, 1'b0);
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        check("ferr_data", data, 8'h81);
        check("ferr_flag", frame_err, 1'b1);
        check("ferr_no_second", overrun, 1'b0);
        pulse_clear();
        frame(8'h7E, CPB);
        check("after_ferr_data", data, 8'h7E);
        check("after_ferr_flag", frame_err, 1'b0);
        pulse_clear();

        // Measure start-to-ready latency at a fixed tick phase, then clear on the load cycle
        align_phase();
        chk_en = 1'b0;
        n_lat  = 0;
        fork
            send_frame(8'h24, CPB, 1'b1, CPB);
            begin
                for (int k = 1; k <= 1000; k++) begin
                    @(negedge clk);
                    if (ready) begin
                        n_lat = k;
                        break;
                    end
                end
            end
        join
        check_range("ready_latency", n_lat, CPB * 19 / 2, CPB * 19 / 2 + TD + 5);
        if (n_lat < 2) n_lat = CPB * 19 / 2 + 4;
        repeat (8) @(negedge clk);
        model_char(8'h24, 1'b1, 1'b0);
        chk_en = 1'b1;
        repeat (8) @(negedge clk);
        align_phase();
        chk_en = 1'b0;
        fork
            send_frame(8'h42, CPB, 1'b1, CPB);
            begin
                repeat (n_lat - 1) @(negedge clk);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        model_char(8'h42, 1'b1, 1'b1);
        chk_en = 1'b1;
        check("clrload_ready", ready, 1'b1);
        check("clrload_data", data, 8'h42);
        check("clrload_overrun", overrun, 1'b0);
        repeat (4) @(negedge clk);

        // Reset in the middle of bit 4 of 0xFF
        chk_en = 1'b0;
        fork
            send_frame(8'hFF, CPB, 1'b1, CPB);
            begin
                repeat (CPB * 5 + CPB / 2) @(negedge clk);
                reset = 1'b1;
                repeat (4) @(negedge clk);
                reset = 1'b0;
            end
        join
        model_reset();
        repeat (8) @(negedge clk);
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_ready", ready, 1'b0);
        check("abort_data", data, 8'h00);
        check("abort_busy", busy, 1'b0);

        // Baud tolerance
        frame(8'h12, CPB - 2);
        check("slow_fast_62", {data, ready, overrun, frame_err}, {8'h12, 3'b100});
        pulse_clear();
        frame(8'h12, CPB + 2);
        check("slow_fast_66", {data, ready, overrun, frame_err}, {8'h12, 3'b100});

        // Line low at reset release is not a start
        chk_en = 1'b0;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        chk_en = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("low_release_busy", busy, 1'b0);
        check("low_release_ready", ready, 1'b0);
        chk_en = 1'b0;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk_en = 1'b1;
        frame(8'h5A, CPB);
        check("final_data", data, 8'h5A);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(10 * 60000);
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
